dc_launch_scheduler: RTL and testbench
======================================

# dc_launch_scheduler

Sequences DAC update strobes from decoded launch commands. Sits downstream of the DC frame dispatcher. Tracks which DAC channels hold a freshly loaded frame (the "armed" set). On a launch command it waits a programmable start delay, then pulses per-channel load strobes a programmed number of times at a programmed period, and finally reports completion.

## Interface
Parameters:
- DAC_CHANNEL, 24, number of DAC channels; must be ≤ 24.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid_frame  in  1  one-cycle pulse: a frame for i_channel_sel was loaded
- i_channel_sel  in  5  channel index qualified by i_valid_frame
- i_launch_cmd  in  4x32  command words [0..3], stable while i_launch_valid high
- i_launch_valid  in  1  command-present level; accepted on its 0→1 edge
- o_dac_load  out  DAC_CHANNEL  per-channel one-cycle load strobes
- o_armed  out  DAC_CHANNEL  channels holding an unconsumed frame
- o_busy  out  1  high in DELAY, FIRE, PERIOD
- o_done  out  1  one-cycle pulse after the final fire
- o_err  out  1  one-cycle pulse on a rejected command
- o_fire_cnt  out  32  fires issued in the current/last run

## Operation
- Command format:
  - word0[31:24] opcode: 0x01 START, 0x02 ABORT; others illegal.
  - word0[23:0] channel mask.
  - word1 start delay (cycles).
  - word2 period (cycles; 0 treated as 1).
  - word3 repeat count.
- Edge detect: a registered copy of i_launch_valid (reset 0) detects the edge. One command per rising edge. A held-high level is not re-accepted.
- Arming:
  - i_valid_frame with i_channel_sel < DAC_CHANNEL sets o_armed[sel].
  - An out-of-range sel is ignored.
- States IDLE, DELAY, FIRE, PERIOD.
- IDLE, START accepted:
  - Reject with o_err, staying IDLE, if repeat == 0, mask == 0, or (mask & ~o_armed) != 0.
  - Otherwise latch mask, delay, period and count, and clear o_fire_cnt.
  - Go to DELAY with delay counter = word1, or directly to FIRE if word1 == 0.
- DELAY: decrement each cycle; on reaching 1, go to FIRE next cycle.
- FIRE (one cycle):
  - o_dac_load = latched mask, and o_fire_cnt increments.
  - If fires == repeat: clear latched-mask bits in o_armed, pulse o_done next cycle, go to IDLE.
  - Else go to PERIOD with counter = period−1. If period ≤ 1, go directly back to FIRE.
- PERIOD: decrement; at 1, go to FIRE.
- ABORT:
  - In any non-IDLE state: go to IDLE next cycle with no o_dac_load, no o_done, and o_armed unchanged.
  - In IDLE: no-op.
- START while o_busy: ignored, o_err pulse.
- Illegal opcode in any state: o_err pulse, no state change.
- Simultaneous i_valid_frame and final-fire clear on the same channel: set wins, so the channel stays armed.
- Frames arriving during a run only update o_armed and do not alter the latched mask.
- Counters are 32-bit unsigned; no wrap is reachable since fires ≤ repeat.

## Timing
- Reset (async assert, sync release) clears all outputs and registers: o_dac_load=0, o_armed=0, o_busy=0, o_done=0, o_err=0, o_fire_cnt=0, state IDLE, edge register 0.
- Latency, with the rising edge sampled at clock edge T:
  - First o_dac_load at T+1+delay (delay=0 → T+1).
  - Subsequent fires every max(period,1) cycles.
  - o_done at last fire +1.
  - o_busy falls in the o_done cycle.
- o_err asserts in cycle T+1 for one cycle.
- ABORT takes effect at T+1; no strobe is issued at T+1 even if a fire was due.
- All outputs are registered.

## Test plan
- Arm ch3 and ch5 via i_valid_frame; START mask=0x28, delay=4, period=10, count=3 → o_dac_load=0x28 at T+5, T+15, T+25; o_done at T+26; o_armed=0; o_fire_cnt=3.
- START mask=0x01 with only ch2 armed → o_err pulse at T+1, no strobes, state IDLE.
- START delay=0, period=0, count=4 on armed ch0 → strobes on 4 consecutive cycles T+1..T+4, o_done at T+5.
- ABORT two cycles into a delay=100 run → o_busy low at T+1, no o_dac_load, o_armed unchanged; a second START is then accepted.
- i_valid_frame for ch7 in the same cycle as the final fire covering ch7 → o_armed[7]=1 afterwards.
- Hold i_launch_valid high for 50 cycles with count=1 → exactly one fire. Assert i_rst_n low mid-PERIOD → all outputs 0 immediately.

Source files
------------

// File: rtl/dc_launch_scheduler.sv
// Launch scheduler: tracks armed DAC channels and, on a START command, waits a
// start delay then pulses the latched channel mask a programmed number of times.
module dc_launch_scheduler #(
  parameter int DAC_CHANNEL = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid_frame,
  input  logic [4:0]             i_channel_sel,
  input  logic [3:0][31:0]       i_launch_cmd,
  input  logic                   i_launch_valid,
  output logic [DAC_CHANNEL-1:0] o_dac_load,
  output logic [DAC_CHANNEL-1:0] o_armed,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [31:0]            o_fire_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_FIRE, S_PERIOD} state_t;
  localparam logic [7:0] OP_START = 8'h01;
  localparam logic [7:0] OP_ABORT = 8'h02;

  state_t                 state_q, state_d;
  logic                   lv_q, lv_d;
  logic [DAC_CHANNEL-1:0] armed_q, armed_d;
  logic [DAC_CHANNEL-1:0] mask_q, mask_d;
  logic [DAC_CHANNEL-1:0] dac_load_q, dac_load_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [31:0]            fire_cnt_q, fire_cnt_d;
  logic [31:0]            rep_q, rep_d;
  logic [31:0]            per_q, per_d;
  logic [31:0]            cnt_q, cnt_d;

  logic                   cmd_edge;
  logic [7:0]             opcode;
  logic [23:0]            cmd_mask;
  logic [23:0]            armed_ext;
  logic                   fire;
  logic                   clr_armed;

  always_comb begin
    state_d    = state_q;
    lv_d       = i_launch_valid;
    armed_d    = armed_q;
    mask_d     = mask_q;
    dac_load_d = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fire_cnt_d = fire_cnt_q;
    rep_d      = rep_q;
    per_d      = per_q;
    cnt_d      = cnt_q;
    fire       = 1'b0;
    clr_armed  = 1'b0;

    cmd_edge  = i_launch_valid & ~lv_q;
    opcode    = i_launch_cmd[0][31:24];
    cmd_mask  = i_launch_cmd[0][23:0];
    // Mask bits above the implemented channels read as unarmed, forcing a reject.
    armed_ext = 24'(armed_q);

    if (cmd_edge && opcode == OP_ABORT && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      if (cmd_edge && opcode != OP_START && opcode != OP_ABORT) err_d = 1'b1;
      if (cmd_edge && opcode == OP_START && state_q != S_IDLE) err_d = 1'b1;

      case (state_q)
        S_IDLE: begin
          if (cmd_edge && opcode == OP_START) begin
            if (i_launch_cmd[3] == 32'd0 || cmd_mask == 24'd0 ||
                (cmd_mask & ~armed_ext) != 24'd0) begin
              err_d = 1'b1;
            end else begin
              mask_d     = cmd_mask[DAC_CHANNEL-1:0];
              per_d      = i_launch_cmd[2];
              rep_d      = i_launch_cmd[3];
              fire_cnt_d = 32'd0;
              if (i_launch_cmd[1] == 32'd0) begin
                state_d    = S_FIRE;
                dac_load_d = cmd_mask[DAC_CHANNEL-1:0];
                fire_cnt_d = 32'd1;
              end else begin
                state_d = S_DELAY;
                cnt_d   = i_launch_cmd[1];
              end
            end
          end
        end
        S_DELAY: begin
          if (cnt_q == 32'd1) fire = 1'b1;
          else cnt_d = cnt_q - 32'd1;
        end
        S_FIRE: begin
          if (fire_cnt_q == rep_q) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            clr_armed = 1'b1;
          end else if (per_q <= 32'd1) begin
            fire = 1'b1;
          end else begin
            state_d = S_PERIOD;
            cnt_d   = per_q - 32'd1;
          end
        end
        S_PERIOD: begin
          if (cnt_q == 32'd1) fire = 1'b1;
          else cnt_d = cnt_q - 32'd1;
        end
        default: state_d = S_IDLE;
      endcase

      // The strobe is registered on entry to FIRE so it appears in the FIRE cycle.
      if (fire) begin
        state_d    = S_FIRE;
        dac_load_d = mask_q;
        fire_cnt_d = fire_cnt_q + 32'd1;
      end
    end

    if (clr_armed) armed_d = armed_q & ~mask_q;
    for (int i = 0; i < DAC_CHANNEL; i++) begin
      if (i_valid_frame && i_channel_sel == 5'(i)) armed_d[i] = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      lv_q       <= 1'b0;
      armed_q    <= '0;
      mask_q     <= '0;
      dac_load_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fire_cnt_q <= 32'd0;
      rep_q      <= 32'd0;
      per_q      <= 32'd0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      lv_q       <= lv_d;
      armed_q    <= armed_d;
      mask_q     <= mask_d;
      dac_load_q <= dac_load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fire_cnt_q <= fire_cnt_d;
      rep_q      <= rep_d;
      per_q      <= per_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_dac_load = dac_load_q;
  assign o_armed    = armed_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_fire_cnt = fire_cnt_q;

endmodule

// File: tb/tb_dc_launch_scheduler.sv
// Directed bench for dc_launch_scheduler; expected strobe/done/err events are
// queued at command time and compared against the outputs every cycle.
module tb_dc_launch_scheduler;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_frame;
  logic [4:0]       channel_sel;
  logic [3:0][31:0] launch_cmd;
  logic             launch_valid;
  logic [23:0]      dac_load;
  logic [23:0]      armed;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      fire_cnt;

  dc_launch_scheduler #(.DAC_CHANNEL(24)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid_frame  (valid_frame),
    .i_channel_sel  (channel_sel),
    .i_launch_cmd   (launch_cmd),
    .i_launch_valid (launch_valid),
    .o_dac_load     (dac_load),
    .o_armed        (armed),
    .o_busy         (busy),
    .o_done         (done),
    .o_err          (err),
    .o_fire_cnt     (fire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [23:0] v;
  } ev_t;

  ev_t ld_q[$];
  int  dn_q[$];
  int  er_q[$];
  int  cyc;
  int  checks;
  int  errors;
  int  t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h at sample %0d", tag, obs, exp, cyc);
    end
  endtask

  // Samples are taken 1 time unit after each rising edge; index = edge count.
  task automatic step();
    ev_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (ld_q.size() != 0 && ld_q[0].c == cyc) begin
      e = ld_q.pop_front();
      chk("dac_load", 32'(dac_load), 32'(e.v));
    end else begin
      chk("dac_load_quiet", 32'(dac_load), 32'd0);
    end
    if (dn_q.size() != 0 && dn_q[0] == cyc) begin
      void'(dn_q.pop_front());
      chk("done", 32'(done), 32'd1);
    end else begin
      chk("done_quiet", 32'(done), 32'd0);
    end
    if (er_q.size() != 0 && er_q[0] == cyc) begin
      void'(er_q.pop_front());
      chk("err", 32'(err), 32'd1);
    end else begin
      chk("err_quiet", 32'(err), 32'd0);
    end
  endtask

  // Edge T is the sample index of the command's accepting edge; an output that
  // appears in cycle T+k is seen at sample T+k-1.
  task automatic push_run(input int tt, input logic [23:0] m, input int d, input int p, input int n);
    int s;
    int pp;
    ev_t e;
    pp = (p == 0) ? 1 : p;
    s  = tt + d;
    for (int k = 0; k < n; k++) begin
      e.c = s;
      e.v = m;
      ld_q.push_back(e);
      if (k < n - 1) s += pp;
    end
    dn_q.push_back(s + 1);
  endtask

  task automatic arm(input logic [4:0] ch);
    valid_frame = 1'b1;
    channel_sel = ch;
    step();
    valid_frame = 1'b0;
  endtask

  task automatic launch(input logic [7:0] op, input logic [23:0] m, input int d, input int p,
                        input int n, input bit exp_err, input bit exp_run, output int tt);
    launch_cmd[0] = {op, m};
    launch_cmd[1] = d;
    launch_cmd[2] = p;
    launch_cmd[3] = n;
    launch_valid  = 1'b1;
    tt = cyc + 1;
    if (exp_err) er_q.push_back(tt);
    if (exp_run) push_run(tt, m, d, p, n);
    step();
    launch_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((ld_q.size() + dn_q.size() + er_q.size()) != 0 && n < 400) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(ld_q.size() + dn_q.size() + er_q.size()), 32'd0);
    step();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    valid_frame  = 1'b0;
    channel_sel  = 5'd0;
    launch_cmd   = '0;
    launch_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dac_load", 32'(dac_load), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_fire_cnt", fire_cnt, 32'd0);
    rst_n = 1'b1;

    // Basic run with start delay and period.
    arm(5'd3);
    arm(5'd5);
    chk("armed_3_5", 32'(armed), 32'h28);
    launch(8'h01, 24'h28, 4, 10, 3, 1'b0, 1'b1, t);
    chk("busy_run1", 32'(busy), 32'd1);
    drain();
    chk("armed_after_run1", 32'(armed), 32'd0);
    chk("fire_cnt_run1", fire_cnt, 32'd3);
    chk("busy_after_run1", 32'(busy), 32'd0);

    // Unarmed channel, empty mask, zero count, illegal opcode: all rejected.
    arm(5'd2);
    launch(8'h01, 24'h01, 2, 1, 1, 1'b1, 1'b0, t);
    chk("busy_reject", 32'(busy), 32'd0);
    step();
    launch(8'h01, 24'h00, 2, 1, 1, 1'b1, 1'b0, t);
    step();
    launch(8'h01, 24'h04, 2, 1, 0, 1'b1, 1'b0, t);
    step();
    launch(8'h07, 24'h04, 2, 1, 1, 1'b1, 1'b0, t);
    step();
    launch(8'h02, 24'h04, 0, 0, 0, 1'b0, 1'b0, t);
    drain();
    chk("armed_after_rejects", 32'(armed), 32'h04);

    // Zero delay, zero period: back-to-back strobes.
    arm(5'd0);
    launch(8'h01, 24'h01, 0, 0, 4, 1'b0, 1'b1, t);
    drain();
    chk("armed_after_b2b", 32'(armed), 32'h04);
    chk("fire_cnt_b2b", fire_cnt, 32'd4);

    // ABORT during a long delay, then a fresh START.
    arm(5'd0);
    launch(8'h01, 24'h01, 100, 1, 1, 1'b0, 1'b0, t);
    step();
    step();
    launch(8'h02, 24'h00, 0, 0, 0, 1'b0, 1'b0, t);
    chk("busy_after_abort", 32'(busy), 32'd0);
    repeat (5) step();
    chk("armed_after_abort", 32'(armed), 32'h05);
    launch(8'h01, 24'h01, 2, 3, 2, 1'b0, 1'b1, t);
    drain();
    chk("armed_after_restart", 32'(armed), 32'h04);
    chk("fire_cnt_restart", fire_cnt, 32'd2);

    // Frame on ch7 coincident with the final fire keeps ch7 armed.
    arm(5'd7);
    arm(5'd25);
    chk("armed_out_of_range", 32'(armed), 32'h84);
    launch(8'h01, 24'h80, 1, 2, 2, 1'b0, 1'b1, t);
    while (cyc < t + 3) step();
    valid_frame = 1'b1;
    channel_sel = 5'd7;
    step();
    valid_frame = 1'b0;
    drain();
    chk("armed_collision", 32'(armed), 32'h84);

    // START while busy is flagged and does not disturb the run.
    launch(8'h01, 24'h04, 10, 1, 1, 1'b0, 1'b1, t);
    step();
    launch(8'h01, 24'h04, 0, 0, 1, 1'b1, 1'b0, t);
    step();
    launch(8'h09, 24'h04, 0, 0, 1, 1'b1, 1'b0, t);
    drain();
    chk("armed_after_busy_start", 32'(armed), 32'h80);

    // Held-high launch_valid yields exactly one run.
    arm(5'd2);
    launch_cmd[0] = {8'h01, 24'h04};
    launch_cmd[1] = 32'd3;
    launch_cmd[2] = 32'd1;
    launch_cmd[3] = 32'd1;
    launch_valid  = 1'b1;
    t = cyc + 1;
    push_run(t, 24'h04, 3, 1, 1);
    repeat (50) step();
    launch_valid = 1'b0;
    drain();
    chk("fire_cnt_hold", fire_cnt, 32'd1);
    chk("armed_after_hold", 32'(armed), 32'h80);

    // Asynchronous reset in the middle of a PERIOD wait.
    arm(5'd2);
    launch(8'h01, 24'h04, 0, 20, 3, 1'b0, 1'b1, t);
    repeat (5) step();
    chk("busy_mid_period", 32'(busy), 32'd1);
    chk("fire_cnt_mid_period", fire_cnt, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_dac_load", 32'(dac_load), 32'd0);
    chk("arst_armed", 32'(armed), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_fire_cnt", fire_cnt, 32'd0);
    ld_q.delete();
    dn_q.delete();
    er_q.delete();
    rst_n = 1'b1;
    repeat (25) step();
    chk("busy_after_arst", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
